// File: rtl/uart_tx_serializer.sv
// UART transmit path: a 16-entry byte FIFO feeding a frame serializer.
// Frames are start, 5..8 data bits sent LSB first, optional parity, then 1 or 2 stop bits.
// Every bit lasts 16 enable ticks.
// The line output is registered one clock behind the FSM. The only exception is break,
// which forces the line low immediately.
module uart_tx_serializer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_PTR_W = 4
) (
    input  logic       clk,
    input  logic       wb_rst_ni,
    input  logic [7:0] lcr,
    input  logic       tf_push,
    input  logic [7:0] wb_dat_i,
    input  logic       enable,
    input  logic       tx_reset,
    output logic       stx_pad_o,
    output logic [2:0] state,
    output logic [4:0] tf_count,
    output logic       tf_overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } tx_state_e;

    tx_state_e             state_reg, state_next;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [4:0]            count_reg;
    logic                  overrun_reg;
    logic [3:0]            tick_reg, tick_next;
    logic [7:0]            shift_reg, shift_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    logic                  par_reg, par_next;
    logic                  stx_reg, stx_next;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic                  bit_done;
    logic [2:0]            last_bit;

    // When the FIFO is full, a push is still accepted if a pop happens in the same cycle,
    // because that pop frees the slot. A flush cancels any push in its cycle.
    assign full     = (count_reg == 5'(FIFO_DEPTH));
    assign push_ok  = tf_push && (!full || pop) && !tx_reset;
    assign bit_done = enable && (tick_reg == 4'hF);
    // Index of the final data bit: word length 5..8 maps to 4..7
    assign last_bit = 3'd4 + {1'b0, lcr[1:0]};

    // FIFO storage; written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wb_dat_i;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else if (tx_reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
            if (tf_push && full && !pop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Serializer state, bit timing and registered line output
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg   <= S_IDLE;
            tick_reg    <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            par_reg     <= 1'b0;
            stx_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            par_reg     <= par_next;
            stx_reg     <= stx_next;
        end
    end

    // Next-state logic, FIFO pop decision and line level for the current bit
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        par_next     = par_reg;
        stx_next     = 1'b1;
        pop          = 1'b0;
        if (enable) begin
            tick_next = tick_reg + 4'd1;
        end
        case (state_reg)
            S_IDLE: begin
                tick_next = '0;
                if (enable && (count_reg != 5'd0)) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr_reg];
                    bit_cnt_next = '0;
                    par_next     = 1'b0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                stx_next = 1'b0;
                if (bit_done) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                stx_next = shift_reg[0];
                if (bit_done) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    par_next     = par_reg ^ shift_reg[0];
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == last_bit) begin
                        state_next = lcr[3] ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                // Stick parity sends a constant. Otherwise the bit is the data XOR,
                // inverted for odd parity.
                stx_next = lcr[5] ? ~lcr[4] : (lcr[4] ? par_reg : ~par_reg);
                if (bit_done) begin
                    state_next = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_done) begin
                    state_next = lcr[2] ? S_STOP2 : S_IDLE;
                end
            end
            S_STOP2: begin
                if (bit_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                tick_next  = '0;
            end
        endcase
    end

    assign stx_pad_o  = stx_reg & ~lcr[6];
    assign state      = state_reg;
    assign tf_count   = count_reg;
    assign tf_overrun = overrun_reg;

endmodule
